// File: rtl/dmem_ctrl.sv
// ============================================================================
// Module   : dmem_ctrl
// Purpose  : Parametrised MIPS data memory with byte/half/word access,
//            wait-state response timing and a post-reset clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH_WORDS    = 256,
  parameter int WAIT_STATES    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int c_IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam state_t             c_RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
  localparam logic [3:0]         c_WAIT_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX    = c_IDX_W'(DEPTH_WORDS - 1);

  state_t               r_state;
  state_t               w_next;
  logic [c_IDX_W-1:0]   r_clr_ptr;
  logic [3:0]           r_wcnt;
  logic [31:0]          r_mem [DEPTH_WORDS];
  logic [31:0]          r_rdata;
  logic                 r_err;

  logic [c_IDX_W-1:0]   w_idx;
  logic [1:0]           w_lane;
  logic                 w_range_err;
  logic                 w_err;
  logic                 w_fire;
  logic [3:0]           w_be;
  logic [31:0]          w_wdata;
  logic [31:0]          w_word;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [31:0]          w_ext;

  assign w_idx  = req_addr[c_IDX_W+1:2];
  assign w_lane = req_addr[1:0];
  assign w_fire = req_valid && (r_state == S_IDLE);

  // Any address bit above the array span makes the request out of range
  generate
    if (ADDR_WIDTH > c_IDX_W + 2) begin : g_range
      assign w_range_err = |req_addr[ADDR_WIDTH-1:c_IDX_W+2];
    end else begin : g_no_range
      assign w_range_err = 1'b0;
    end
  endgenerate

  assign w_err = (req_size == 2'b11)
              || ((req_size == 2'b01) && req_addr[0])
              || ((req_size == 2'b10) && (w_lane != 2'b00))
              || w_range_err;

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

  // Store data is replicated across lanes so the byte enables alone pick the target
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = req_wdata;
    w_ext   = 32'd0;
    case (req_size)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{req_wdata[7:0]}};
        w_ext   = req_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
        w_ext   = req_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      end
      2'b10: begin
        w_be  = 4'b1111;
        w_ext = w_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_clr_ptr] <= 32'd0;
      end else if (w_fire && req_we && !w_err) begin
        for (int i = 0; i < 4; i++) begin
          if (w_be[i]) begin
            r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_ptr <= '0;
      r_wcnt    <= 4'd0;
      r_rdata   <= 32'd0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == S_CLEAR) begin
        r_clr_ptr <= r_clr_ptr + 1'b1;
      end
      if (w_fire) begin
        r_wcnt  <= c_WAIT_LOAD;
        r_err   <= w_err;
        r_rdata <= (w_err || req_we) ? 32'd0 : w_ext;
      end else if (r_state == S_WAIT) begin
        r_wcnt <= r_wcnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_RESET_STATE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      S_CLEAR: begin
        busy = 1'b1;
        if (r_clr_ptr == c_LAST_IDX) w_next = S_IDLE;
      end
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        if (r_wcnt == 4'd0) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign rsp_rdata = (r_state == S_RESP) ? r_rdata : 32'd0;
  assign rsp_err   = (r_state == S_RESP) ? r_err : 1'b0;

endmodule

`default_nettype wire

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised data memory for the MIPS datapath; successor to the fixed 32-word data RAM.
- Adds configurable depth, byte/half/word loads and stores with sign or zero extension, and a valid/ready request port.
- Responses arrive after a programmable number of wait states; alignment and range errors are flagged.
- A hardware clear sequencer zeroes the array after reset; no combinational clearing.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DEPTH_WORDS, 256, number of 32-bit words (power of two, >=2).
- WAIT_STATES, 1, extra cycles between acceptance and response (0..15).
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip clear, contents undefined.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned, out of range or illegal size.
- busy  out  1  clear sequence in progress.

Behaviour:
- Reset (sync, active-high): state <= CLEAR if CLEAR_ON_RESET, else IDLE. clr_ptr <= 0.
  - Outputs after reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=CLEAR_ON_RESET.
- CLEAR: each cycle writes 0 to mem[clr_ptr] and increments clr_ptr.
  - After writing index DEPTH_WORDS-1, next state is IDLE.
  - Clear takes exactly DEPTH_WORDS cycles. busy=1 throughout; req_ready=0.
- IDLE: req_ready=1.
  - Handshake fires when req_valid && req_ready. The request is decoded and checked in that cycle.
  - Next state is WAIT if WAIT_STATES>0, else RESP.
- WAIT: a down-counter loaded with WAIT_STATES-1; when it reaches 0, next state is RESP. req_ready=0.
- RESP: rsp_valid=1 with registered rsp_rdata/rsp_err for exactly one cycle, then IDLE.
  - No response back-pressure. req_ready=0 in RESP, so back-to-back requests are spaced by WAIT_STATES+2 cycles.
- Latency: rsp_valid is asserted WAIT_STATES+1 cycles after the acceptance edge.
- Word index = req_addr[log2(DEPTH_WORDS)+1:2]. Byte lane = req_addr[1:0], little-endian (lane 0 = bits [7:0]).
- Error checks:
  - Error if req_size=11.
  - Error if half and addr[0]=1.
  - Error if word and addr[1:0]!=0.
  - Error if req_addr >= 4*DEPTH_WORDS (upper address bits nonzero).
  - On error: no memory write, rsp_err=1, rsp_rdata=0.
- Stores: performed on the acceptance edge, using a byte-enable write of the selected lanes only; other lanes are unchanged. Store response: rsp_rdata=0, rsp_err as checked.
- Loads: the word is read and the lane/half extracted on the acceptance edge into a holding register, then presented in RESP.
  - Byte: bit 7 (signed) or zero extended to 32.
  - Half: bit 15 (signed) or zero extended to 32.
  - Word: returned unchanged.
- Ordering: a request sees all stores accepted before it (read-after-write is coherent because writes occur only at acceptance).
- Reset mid-operation (WAIT, RESP or CLEAR): the pending response is dropped, rsp_valid=0 on the cycle after the reset edge, and the clear sequence restarts at 0.
  - A store accepted before reset keeps its effect until cleared.
- req_valid outside IDLE is ignored; the requester must hold the request until req_ready.

Test Plan:
- Clear: DEPTH_WORDS=8, CLEAR_ON_RESET=1, release reset -> busy=1 for 8 cycles, req_ready rises on cycle 9; word loads of addresses 0x00..0x1C all return 0.
- Byte stores: store byte 0xAB to 0x05, then 0xCD to 0x06 -> word load of 0x04 returns 0x00CDAB00; signed byte load of 0x05 returns 0xFFFFFFAB; unsigned returns 0x000000AB.
- Half access and latency: store half 0x8001 to 0x0A, WAIT_STATES=3 -> rsp_valid exactly 4 cycles after acceptance. Signed half load of 0x0A returns 0xFFFF8001; unsigned returns 0x00008001.
- Errors:
  - Word load at 0x02 -> rsp_err=1, rsp_rdata=0.
  - Half store at 0x03 with 0xFFFF -> rsp_err=1, word 0x00 unchanged.
  - size=11 -> rsp_err=1.
  - Address 4*DEPTH_WORDS -> rsp_err=1, no write.
- Handshake: hold req_valid=1 with four word stores, WAIT_STATES=0 -> accepted every 2 cycles, exactly one rsp_valid pulse per request; read-back matches 0x11111111, 0x22222222, 0x33333333, 0x44444444.
- Reset mid-WAIT: load accepted with WAIT_STATES=5, reset on wait cycle 2 -> no rsp_valid, busy=1 next cycle, full clear repeats, then normal operation resumes.
